// File: rtl/capi_put_pkg.sv
// Shared constants, beat layout and parity helper for the CAPI put-data path.
package capi_put_pkg;

  localparam int unsigned BEAT_BYTES = 16;
  localparam int unsigned BCNT_WIDTH = 10;
  localparam int unsigned BRD_LAT    = 2;
  localparam int unsigned DATA_WIDTH = 130;

  // Stream beat: two odd-parity bits (bit 129 covers [127:64], bit 128 covers [63:0]) above 128b data.
  typedef struct packed {
    logic [1:0]   par;
    logic [127:0] data;
  } beat_t;

  // True when a 64b half and its odd-parity bit do not carry an odd number of ones.
  function automatic logic odd_par_err(input logic [63:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/capi_put_tag_fifo.sv
// Free-list FIFO of buffer tags, preloaded with 0..DEPTH-1 in ascending order on reset.
// Ports: clk, rst_n (async active-low), push_i/push_tag_i return a tag, pop_i consumes
// head_tag_o, empty_o flags no free tag. Push and pop may happen in the same cycle.
module capi_put_tag_fifo #(
  parameter int unsigned tag_width = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [tag_width-1:0] push_tag_i,
  input  logic                 pop_i,
  output logic [tag_width-1:0] head_tag_o,
  output logic                 empty_o
);

  localparam int unsigned DEPTH = 2 ** tag_width;
  localparam int unsigned CW    = tag_width + 1;

  logic [tag_width-1:0] mem_q [DEPTH];
  logic [tag_width-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pop_ok, push_ok;

  assign empty_o    = (cnt_q == '0);
  assign head_tag_o = mem_q[rd_ptr_q];
  assign pop_ok     = pop_i & ~empty_o;
  // A push into a full list is only legal when a pop frees a slot the same cycle.
  assign push_ok    = push_i & ((cnt_q != CW'(DEPTH)) | pop_ok);

  // Occupancy update.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointers; reset leaves the list full with tags in ascending order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= CW'(DEPTH);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= tag_width'(i);
      end
    end else begin
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + tag_width'(1);
      end
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_tag_i;
        wr_ptr_q        <= wr_ptr_q + tag_width'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/capi_put_data_plus.sv
// Write-direction CAPI put-data path: packs a 130b AFU stream into tag-indexed 512B
// buffers, issues one write command per buffer, serves PSL buffer reads and frees tags
// on CAPI responses.
// Ports: clk, reset (async active-low); put_data_* stream in; o_cmd_* write command out;
// i_brd_*/o_brd_* buffer-read request/data; i_rsp_* response in; o_rsp_rc, o_rm_err,
// o_perror sticky status.
module capi_put_data_plus
  import capi_put_pkg::*;
#(
  parameter int unsigned lcl_tag_width    = 3,
  parameter int unsigned beat_512_width   = 5,
  parameter int unsigned uid_width        = 1,
  parameter int unsigned uid              = 0,
  parameter int unsigned rc_width         = 8,
  parameter int unsigned rdata_addr_width = uid_width + lcl_tag_width + beat_512_width
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_disable,
  input  logic                        put_data_v,
  output logic                        put_data_r,
  input  logic                        put_data_e,
  input  logic [3:0]                  put_data_c,
  input  logic [DATA_WIDTH-1:0]       put_data_d,
  output logic                        o_cmd_v,
  input  logic                        o_cmd_r,
  output logic [lcl_tag_width-1:0]    o_cmd_tag,
  output logic [BCNT_WIDTH-1:0]       o_cmd_bcnt,
  output logic                        o_cmd_f,
  output logic                        o_cmd_e,
  input  logic                        i_brd_v,
  input  logic [rdata_addr_width-1:0] i_brd_a,
  output logic                        o_brd_v,
  output logic [DATA_WIDTH-1:0]       o_brd_d,
  input  logic                        i_rsp_v,
  input  logic [lcl_tag_width-1:0]    i_rsp_tag,
  input  logic [rc_width-1:0]         i_rsp_rc,
  output logic [rc_width-1:0]         o_rsp_rc,
  output logic                        o_rm_err,
  output logic                        o_perror
);

  localparam int unsigned BUF_AW   = lcl_tag_width + beat_512_width;
  localparam int unsigned MAX_TAGS = 2 ** lcl_tag_width;

  logic                      s1_disable_q;
  logic                      free_empty;
  logic [lcl_tag_width-1:0]  cur_tag;
  logic [beat_512_width-1:0] beat_cnt_q;
  logic                      first_q;
  logic                      accept, close, last_beat, par_err;
  logic [BCNT_WIDTH-1:0]     tail_bytes, cmd_bcnt_d;
  beat_t                     beat;

  logic                      rsp_v_q;
  logic [lcl_tag_width-1:0]  rsp_tag_q;
  logic [rc_width-1:0]       rsp_rc_q;
  logic [MAX_TAGS-1:0]       inflight_q, inflight_d;
  logic                      rsp_hit, rsp_miss;

  logic                      brd_match;
  logic [BUF_AW-1:0]         brd_addr_q;
  logic [BRD_LAT-2:0]        brd_vld_q;

  logic [DATA_WIDTH-1:0]     base_mem [2 ** BUF_AW];

  // Stream handshake: a beat may close a buffer, so a pending command must be leaving.
  assign put_data_r = ~free_empty & ~s1_disable_q & (~o_cmd_v | o_cmd_r);
  assign accept     = put_data_v & put_data_r;
  assign last_beat  = (beat_cnt_q == '1);
  assign close      = accept & (put_data_e | last_beat);

  // Byte count: full beats so far plus the closing beat (partial only on the e beat).
  assign tail_bytes = (put_data_e && (put_data_c != 4'd0)) ? BCNT_WIDTH'(put_data_c)
                                                           : BCNT_WIDTH'(BEAT_BYTES);
  assign cmd_bcnt_d = BCNT_WIDTH'(beat_cnt_q) * BCNT_WIDTH'(BEAT_BYTES) + tail_bytes;

  assign beat    = put_data_d;
  assign par_err = accept & (odd_par_err(beat.data[63:0],   beat.par[0]) |
                             odd_par_err(beat.data[127:64], beat.par[1]));

  // Registered response is only honoured for tags currently in flight.
  assign rsp_hit  = rsp_v_q &  inflight_q[rsp_tag_q];
  assign rsp_miss = rsp_v_q & ~inflight_q[rsp_tag_q];

  assign brd_match = i_brd_v &
                     (i_brd_a[rdata_addr_width-1 -: uid_width] == uid_width'(uid));

  capi_put_tag_fifo #(
    .tag_width (lcl_tag_width)
  ) u_free_list (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (rsp_hit),
    .push_tag_i (rsp_tag_q),
    .pop_i      (close),
    .head_tag_o (cur_tag),
    .empty_o    (free_empty)
  );

  // In-flight map: the closing tag is free, so it never collides with a clearing tag.
  always_comb begin
    inflight_d = inflight_q;
    if (rsp_hit) begin
      inflight_d[rsp_tag_q] = 1'b0;
    end
    if (close) begin
      inflight_d[cur_tag] = 1'b1;
    end
  end

  // Buffer storage; write-only port plus the registered read below.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_mem[{cur_tag, beat_cnt_q}] <= put_data_d;
    end
  end

  // Control, command, response and buffer-read pipeline state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_disable_q <= 1'b0;
      beat_cnt_q   <= '0;
      first_q      <= 1'b1;
      o_cmd_v      <= 1'b0;
      o_cmd_tag    <= '0;
      o_cmd_bcnt   <= '0;
      o_cmd_f      <= 1'b0;
      o_cmd_e      <= 1'b0;
      inflight_q   <= '0;
      rsp_v_q      <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_rc_q     <= '0;
      o_rsp_rc     <= '0;
      o_rm_err     <= 1'b0;
      o_perror     <= 1'b0;
      brd_addr_q   <= '0;
      brd_vld_q    <= '0;
      o_brd_v      <= 1'b0;
      o_brd_d      <= '0;
    end else begin
      s1_disable_q <= i_disable;

      if (accept) begin
        beat_cnt_q <= close ? '0 : beat_cnt_q + beat_512_width'(1);
      end

      if (close) begin
        first_q    <= put_data_e;
        o_cmd_v    <= 1'b1;
        o_cmd_tag  <= cur_tag;
        o_cmd_bcnt <= cmd_bcnt_d;
        o_cmd_f    <= first_q;
        o_cmd_e    <= put_data_e;
      end else if (o_cmd_r) begin
        o_cmd_v <= 1'b0;
      end

      inflight_q <= inflight_d;
      rsp_v_q    <= i_rsp_v;
      rsp_tag_q  <= i_rsp_tag;
      rsp_rc_q   <= i_rsp_rc;

      if (rsp_v_q && (rsp_rc_q != '0) && (o_rsp_rc == '0)) begin
        o_rsp_rc <= rsp_rc_q;
      end
      if (rsp_miss) begin
        o_rm_err <= 1'b1;
      end
      if (par_err) begin
        o_perror <= 1'b1;
      end

      if (brd_match) begin
        brd_addr_q <= i_brd_a[BUF_AW-1:0];
      end
      brd_vld_q <= (BRD_LAT - 1)'(brd_match);
      o_brd_v   <= brd_vld_q[0];
      o_brd_d   <= base_mem[brd_addr_q];
    end
  end

endmodule

// File: tb/tb_capi_put_data_plus.sv
// Directed self-checking bench for capi_put_data_plus.
module tb_capi_put_data_plus;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_disable;
  logic         put_data_v;
  logic         put_data_r;
  logic         put_data_e;
  logic [3:0]   put_data_c;
  logic [129:0] put_data_d;
  logic         o_cmd_v;
  logic         o_cmd_r;
  logic [2:0]   o_cmd_tag;
  logic [9:0]   o_cmd_bcnt;
  logic         o_cmd_f;
  logic         o_cmd_e;
  logic         i_brd_v;
  logic [8:0]   i_brd_a;
  logic         o_brd_v;
  logic [129:0] o_brd_d;
  logic         i_rsp_v;
  logic [2:0]   i_rsp_tag;
  logic [7:0]   i_rsp_rc;
  logic [7:0]   o_rsp_rc;
  logic         o_rm_err;
  logic         o_perror;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] tag;
    logic [9:0] bcnt;
    logic       f;
    logic       e;
  } cmd_t;
  cmd_t cmd_q[$];

  always #5 clk = ~clk;

  capi_put_data_plus dut (
    .clk        (clk),
    .reset      (reset),
    .i_disable  (i_disable),
    .put_data_v (put_data_v),
    .put_data_r (put_data_r),
    .put_data_e (put_data_e),
    .put_data_c (put_data_c),
    .put_data_d (put_data_d),
    .o_cmd_v    (o_cmd_v),
    .o_cmd_r    (o_cmd_r),
    .o_cmd_tag  (o_cmd_tag),
    .o_cmd_bcnt (o_cmd_bcnt),
    .o_cmd_f    (o_cmd_f),
    .o_cmd_e    (o_cmd_e),
    .i_brd_v    (i_brd_v),
    .i_brd_a    (i_brd_a),
    .o_brd_v    (o_brd_v),
    .o_brd_d    (o_brd_d),
    .i_rsp_v    (i_rsp_v),
    .i_rsp_tag  (i_rsp_tag),
    .i_rsp_rc   (i_rsp_rc),
    .o_rsp_rc   (o_rsp_rc),
    .o_rm_err   (o_rm_err),
    .o_perror   (o_perror)
  );

  // Capture every accepted write command.
  always @(negedge clk) begin
    if (reset && o_cmd_v && o_cmd_r) begin
      cmd_q.push_back('{o_cmd_tag, o_cmd_bcnt, o_cmd_f, o_cmd_e});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [129:0] mk(input logic [127:0] d);
    return {~^d[127:64], ~^d[63:0], d};
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    i_disable  = 1'b0;
    put_data_v = 1'b0;
    put_data_e = 1'b0;
    put_data_c = 4'd0;
    put_data_d = '0;
    o_cmd_r    = 1'b1;
    i_brd_v    = 1'b0;
    i_brd_a    = '0;
    i_rsp_v    = 1'b0;
    i_rsp_tag  = '0;
    i_rsp_rc   = '0;
    repeat (3) tick();
    cmd_q.delete();
    reset = 1'b1;
    tick();
  endtask

  task automatic send(input logic [129:0] d, input logic e, input logic [3:0] c);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    put_data_v = 1'b1;
    put_data_d = d;
    put_data_e = e;
    put_data_c = c;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (put_data_r) ok = 1'b1;
      tick();
      n++;
    end
    put_data_v = 1'b0;
    put_data_e = 1'b0;
    put_data_c = 4'd0;
    if (!ok) chk("send_timeout", 136'(ok), 136'(1));
  endtask

  task automatic wait_cmds(input int n);
    int k;
    k = 0;
    while (cmd_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("cmd_count", 136'(cmd_q.size()), 136'(n));
  endtask

  task automatic expect_cmd(input string tag, input logic [2:0] t, input logic [9:0] b,
                            input logic f, input logic e);
    cmd_t c;
    if (cmd_q.size() == 0) begin
      chk({tag, "_missing"}, 136'(0), 136'(1));
    end else begin
      c = cmd_q.pop_front();
      chk(tag, 136'({c.tag, c.bcnt, c.f, c.e}), 136'({t, b, f, e}));
    end
  endtask

  task automatic rsp(input logic [2:0] t, input logic [7:0] rc);
    i_rsp_v   = 1'b1;
    i_rsp_tag = t;
    i_rsp_rc  = rc;
    tick();
    i_rsp_v   = 1'b0;
  endtask

  task automatic brd_req(input logic [8:0] a);
    i_brd_v = 1'b1;
    i_brd_a = a;
    tick();
    i_brd_v = 1'b0;
  endtask

  logic [129:0] b0, b1, b2, bad;

  initial begin
    // Reset values
    do_reset();
    chk("rst_cmd_v", 136'(o_cmd_v), 136'(0));
    chk("rst_brd_v", 136'(o_brd_v), 136'(0));
    chk("rst_status", 136'({o_rsp_rc, o_rm_err, o_perror}), 136'(0));
    chk("rst_ready", 136'(put_data_r), 136'(1));

    // Disable takes effect one cycle late
    i_disable = 1'b1;
    chk("dis_delay", 136'(put_data_r), 136'(1));
    tick();
    chk("dis_active", 136'(put_data_r), 136'(0));
    i_disable = 1'b0;
    tick();
    chk("dis_release", 136'(put_data_r), 136'(1));

    // 3-beat stream, c=4 on the e beat
    b0 = mk(128'h0000_1111_2222_3333_4444_5555_6666_7777);
    b1 = mk(128'h89ab_cdef_0123_4567_fedc_ba98_7654_3210);
    b2 = mk(128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678);
    send(b0, 1'b0, 4'd0);
    send(b1, 1'b0, 4'd0);
    send(b2, 1'b1, 4'd4);
    wait_cmds(1);
    expect_cmd("cmd_3beat", 3'd0, 10'd36, 1'b1, 1'b1);
    chk("perr_clean", 136'(o_perror), 136'(0));

    brd_req({1'b0, 3'd0, 5'd2});
    chk("brd_lat1", 136'(o_brd_v), 136'(0));
    tick();
    chk("brd_v", 136'(o_brd_v), 136'(1));
    chk("brd_d_beat2", 136'(o_brd_d), 136'(b2));

    brd_req({1'b1, 3'd0, 5'd2});
    tick();
    chk("brd_uid_miss", 136'(o_brd_v), 136'(0));

    i_brd_v = 1'b1;
    i_brd_a = {1'b0, 3'd0, 5'd0};
    tick();
    i_brd_a = {1'b0, 3'd0, 5'd1};
    tick();
    i_brd_v = 1'b0;
    chk("brd_b2b_d0", 136'({o_brd_v, o_brd_d}), 136'({1'b1, b0}));
    tick();
    chk("brd_b2b_d1", 136'({o_brd_v, o_brd_d}), 136'({1'b1, b1}));

    // Command back-pressure holds fields and blocks the stream
    o_cmd_r = 1'b0;
    send(b1, 1'b1, 4'd0);
    repeat (3) tick();
    chk("bp_hold", 136'({o_cmd_v, o_cmd_tag, o_cmd_bcnt, o_cmd_f, o_cmd_e}),
        136'({1'b1, 3'd1, 10'd16, 1'b1, 1'b1}));
    chk("bp_ready", 136'(put_data_r), 136'(0));
    o_cmd_r = 1'b1;
    tick();
    chk("bp_drop", 136'(o_cmd_v), 136'(0));
    expect_cmd("cmd_bp", 3'd1, 10'd16, 1'b1, 1'b1);

    // 64-beat stream -> two full buffers
    do_reset();
    for (int i = 0; i < 64; i++) begin
      send(mk({4{32'(i)}}), (i == 63), 4'd0);
    end
    wait_cmds(2);
    expect_cmd("cmd64_a", 3'd0, 10'd512, 1'b1, 1'b0);
    expect_cmd("cmd64_b", 3'd1, 10'd512, 1'b0, 1'b1);

    // Exhaust the free list with 8 single-beat streams
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(mk(128'(i + 100)), 1'b1, 4'd0);
    end
    chk("empty_ready", 136'(put_data_r), 136'(0));
    wait_cmds(8);
    for (int i = 0; i < 8; i++) begin
      expect_cmd("cmd_single", 3'(i), 10'd16, 1'b1, 1'b1);
    end
    chk("empty_hold", 136'(put_data_r), 136'(0));
    rsp(3'd3, 8'd0);
    chk("free_pending", 136'(put_data_r), 136'(0));
    tick();
    chk("free_ready", 136'(put_data_r), 136'(1));
    send(mk(128'h55), 1'b1, 4'd0);
    wait_cmds(1);
    expect_cmd("cmd_reuse3", 3'd3, 10'd16, 1'b1, 1'b1);

    // Sticky rc, unknown-tag response
    rsp(3'd5, 8'h02);
    rsp(3'd6, 8'h07);
    repeat (2) tick();
    chk("rsp_rc", 136'({o_rsp_rc, o_rm_err}), 136'({8'h02, 1'b0}));
    rsp(3'd5, 8'h00);
    repeat (2) tick();
    chk("rm_err", 136'(o_rm_err), 136'(1));
    send(mk(128'h66), 1'b1, 4'd0);
    send(mk(128'h77), 1'b1, 4'd0);
    chk("free_count", 136'(put_data_r), 136'(0));
    wait_cmds(2);
    expect_cmd("cmd_tag5", 3'd5, 10'd16, 1'b1, 1'b1);
    expect_cmd("cmd_tag6", 3'd6, 10'd16, 1'b1, 1'b1);

    // Bad parity on bit 128 is flagged and stored untouched
    do_reset();
    bad = mk(128'h0123_4567_89ab_cdef_0f0f_f0f0_1234_abcd);
    bad[128] = ~bad[128];
    send(bad, 1'b1, 4'd0);
    chk("perr_set", 136'(o_perror), 136'(1));
    brd_req({1'b0, 3'd0, 5'd0});
    tick();
    chk("perr_data", 136'({o_brd_v, o_brd_d}), 136'({1'b1, bad}));

    // Reset in the middle of a stream discards the partial buffer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(mk(128'(i + 7)), 1'b0, 4'd0);
    end
    do_reset();
    repeat (4) tick();
    chk("mid_rst_nocmd", 136'({o_cmd_v, 32'(cmd_q.size())}), 136'(0));
    send(mk(128'h99), 1'b1, 4'd0);
    wait_cmds(1);
    expect_cmd("cmd_after_rst", 3'd0, 10'd16, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
